// File: rtl/dag_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dag_access_arbiter
// Description : Shares the DAG between sequencer commands and host register
//               accesses. Optional host anti-starvation counter is built
//               when DAG_ACCESS_ARBITER_STARVE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dag_access_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps_req,
  input  logic [13:0] ps_cmd,
  input  logic [15:0] ps_dt,
  output logic        ps_gnt,
  input  logic        hs_req,
  input  logic        hs_wr,
  input  logic [4:0]  hs_add,
  input  logic [15:0] hs_wdt,
  output logic        hs_ack,
  output logic [15:0] hs_rdt,
  output logic        dg_en,
  output logic [13:0] dg_cmd,
  output logic [15:0] bc_dt,
  output logic [4:0]  dg_rd_add,
  input  logic [15:0] dg_bc_dt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISS_PS = 3'd1,
    ISS_HW = 3'd2,
    ISS_HR = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t r_state;
  logic   w_arb;
  logic   w_host_elig;
  logic   w_starve;
  logic   w_ps_win;
  logic   w_host_win;

  // The host is held out while its own access is completing.
  assign w_arb       = (r_state == IDLE) || (r_state == ISS_PS) || (r_state == ACK);
  assign w_host_elig = w_arb && hs_req && (r_state != ACK);
  assign w_ps_win    = w_arb && ps_req && !(w_starve && w_host_elig);
  assign w_host_win  = w_host_elig && !w_ps_win;
  assign ps_gnt      = rst_n && w_ps_win;

`ifdef DAG_ACCESS_ARBITER_STARVE_EN
  localparam int                 c_cnt_w = $clog2(STARVE_LIM + 1);
  localparam logic [c_cnt_w-1:0] c_lim   = c_cnt_w'(STARVE_LIM);

  logic [c_cnt_w-1:0] r_starve_cnt;

  assign w_starve = (r_starve_cnt == c_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_host_win) begin
      r_starve_cnt <= '0;
    end else if (w_host_elig && !w_starve) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  // Strict sequencer priority: the starve condition can never hold.
  assign w_starve = (STARVE_LIM < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      dg_en     <= 1'b0;
      dg_cmd    <= '0;
      bc_dt     <= '0;
      dg_rd_add <= '0;
      hs_ack    <= 1'b0;
      hs_rdt    <= '0;
    end else begin
      dg_en     <= 1'b0;
      dg_cmd    <= '0;
      bc_dt     <= '0;
      dg_rd_add <= '0;
      hs_ack    <= 1'b0;
      case (r_state)
        ISS_HW: begin
          r_state <= ACK;
          hs_ack  <= 1'b1;
        end
        ISS_HR: begin
          r_state <= ACK;
          hs_ack  <= 1'b1;
          hs_rdt  <= dg_bc_dt;
        end
        default: begin
          if (w_ps_win) begin
            r_state <= ISS_PS;
            dg_en   <= 1'b1;
            dg_cmd  <= ps_cmd;
            bc_dt   <= ps_dt;
          end else if (w_host_win) begin
            if (hs_wr) begin
              r_state <= ISS_HW;
              dg_cmd  <= {8'b0, 1'b1, hs_add};
              bc_dt   <= hs_wdt;
            end else begin
              r_state   <= ISS_HR;
              dg_rd_add <= hs_add;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dag_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dag_access_arbiter
// Description : Directed self-checking bench for dag_access_arbiter with a
//               per-cycle reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dag_access_arbiter;

  localparam int LIM = 4;
`ifdef DAG_ACCESS_ARBITER_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ps_req;
  logic [13:0] ps_cmd;
  logic [15:0] ps_dt;
  logic        ps_gnt;
  logic        hs_req;
  logic        hs_wr;
  logic [4:0]  hs_add;
  logic [15:0] hs_wdt;
  logic        hs_ack;
  logic [15:0] hs_rdt;
  logic        dg_en;
  logic [13:0] dg_cmd;
  logic [15:0] bc_dt;
  logic [4:0]  dg_rd_add;
  logic [15:0] dg_bc_dt;

  dag_access_arbiter #(.STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps_req(ps_req), .ps_cmd(ps_cmd), .ps_dt(ps_dt), .ps_gnt(ps_gnt),
    .hs_req(hs_req), .hs_wr(hs_wr), .hs_add(hs_add), .hs_wdt(hs_wdt),
    .hs_ack(hs_ack), .hs_rdt(hs_rdt),
    .dg_en(dg_en), .dg_cmd(dg_cmd), .bc_dt(bc_dt), .dg_rd_add(dg_rd_add),
    .dg_bc_dt(dg_bc_dt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: host_stage 0 = no host access, 1 = on the DAG, 2 = completing.
  int          m_stage;
  bit          m_rd;
  int          m_lost;
  logic        m_en;
  logic [13:0] m_cmd;
  logic [15:0] m_bc;
  logic [15:0] m_rdt;
  logic [4:0]  m_rdadd;
  logic        m_ack;

  function automatic bit host_ok();
    return hs_req && (m_stage == 0);
  endfunction

  function automatic bit seq_wins();
    bit forced;
    forced = STARVE_EN && host_ok() && (m_lost >= LIM);
    return (m_stage != 1) && ps_req && !forced;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= 0; m_rd <= 1'b0; m_lost <= 0;
      m_en <= 1'b0; m_cmd <= '0; m_bc <= '0; m_rdadd <= '0; m_ack <= 1'b0; m_rdt <= '0;
    end else begin
      m_en <= 1'b0; m_cmd <= '0; m_bc <= '0; m_rdadd <= '0; m_ack <= 1'b0;
      if (m_stage == 1) begin
        m_stage <= 2;
        m_ack   <= 1'b1;
        if (m_rd) m_rdt <= dg_bc_dt;
      end else if (seq_wins()) begin
        m_stage <= 0;
        m_en    <= 1'b1;
        m_cmd   <= ps_cmd;
        m_bc    <= ps_dt;
        if (host_ok() && m_lost < LIM) m_lost <= m_lost + 1;
      end else if (host_ok()) begin
        m_stage <= 1;
        m_rd    <= !hs_wr;
        m_lost  <= 0;
        if (hs_wr) begin
          m_cmd <= 14'h0020 | 14'(hs_add);
          m_bc  <= hs_wdt;
        end else begin
          m_rdadd <= hs_add;
        end
      end else begin
        m_stage <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("ps_gnt",    ps_gnt,    rst_n && seq_wins());
    check("dg_en",     dg_en,     m_en);
    check("dg_cmd",    dg_cmd,    m_cmd);
    check("bc_dt",     bc_dt,     m_bc);
    check("dg_rd_add", dg_rd_add, m_rdadd);
    check("hs_ack",    hs_ack,    m_ack);
    check("hs_rdt",    hs_rdt,    m_rdt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ack_at;
  int ack_cnt;

  initial begin
    ps_req = 1'b0; ps_cmd = '0; ps_dt = '0;
    hs_req = 1'b0; hs_wr = 1'b0; hs_add = '0; hs_wdt = '0; dg_bc_dt = '0;

    // Reset state
    #1 rst_n = 1'b0;
    ps_req = 1'b1;
    #1;
    check("rst_gnt", ps_gnt, 0);
    check("rst_en", dg_en, 0);
    check("rst_cmd", dg_cmd, 0);
    check("rst_ack", hs_ack, 0);
    check("rst_rdt", hs_rdt, 0);
    ps_req = 1'b0;
    #10 rst_n = 1'b1;
    tick();

    // Sequencer stream, one command per cycle
    ps_req = 1'b1; ps_cmd = 14'h0A49; ps_dt = 16'h1111;
    #1;
    check("seq_gnt_first", ps_gnt, 1);
    check("seq_en_pre", dg_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        ps_cmd = 14'(14'h0A4A + i);
        ps_dt  = 16'(16'h1111 * (i + 2));
      end else begin
        ps_req = 1'b0;
      end
      #1;
      check("seq_en", dg_en, 1);
      check("seq_cmd", dg_cmd, 32'(14'h0A49 + i));
      check("seq_bc", bc_dt, 32'(16'h1111 * (i + 1)));
      check("seq_gnt", ps_gnt, (i < 2) ? 1 : 0);
    end
    tick();
    #1 check("seq_en_end", dg_en, 0);

    // Host write
    hs_req = 1'b1; hs_wr = 1'b1; hs_add = 5'b10011; hs_wdt = 16'h1234;
    tick();
    #1;
    check("hw_cmd", dg_cmd, 32'h0033);
    check("hw_bc", bc_dt, 32'h1234);
    check("hw_en", dg_en, 0);
    check("hw_ack_early", hs_ack, 0);
    tick();
    hs_req = 1'b0;
    #1;
    check("hw_ack", hs_ack, 1);
    check("hw_rdt_kept", hs_rdt, 0);
    check("hw_cmd_ack", dg_cmd, 0);
    tick();
    #1 check("hw_ack_end", hs_ack, 0);

    // Host read
    hs_req = 1'b1; hs_wr = 1'b0; hs_add = 5'b00101; dg_bc_dt = 16'hBEEF;
    tick();
    #1;
    check("hr_rd_add", dg_rd_add, 5);
    check("hr_cmd", dg_cmd, 0);
    tick();
    hs_req = 1'b0;
    #1;
    check("hr_ack", hs_ack, 1);
    check("hr_rdt", hs_rdt, 32'hBEEF);
    check("hr_rd_add_ack", dg_rd_add, 0);
    dg_bc_dt = 16'h0000;
    tick();
    #1;
    check("hr_ack_end", hs_ack, 0);
    check("hr_rdt_hold", hs_rdt, 32'hBEEF);

    // Starvation: both requesters held high
    ps_req = 1'b1; ps_cmd = 14'h0100; ps_dt = 16'h0F0F;
    hs_req = 1'b1; hs_wr = 1'b1; hs_add = 5'b00001; hs_wdt = 16'h5555;
    ack_at = 0;
    for (int c = 1; c <= 12 && ack_at == 0; c++) begin
      #1;
      if (c == 5) check("starve_gnt_edge5", ps_gnt, STARVE_EN ? 0 : 1);
      tick();
      if (hs_ack) begin
        ack_at = c;
        hs_req = 1'b0;
      end
    end
    check("starve_ack_at", ack_at, STARVE_EN ? 6 : 0);
    if (ack_at == 0) begin
      ps_req = 1'b0;
      for (int c = 1; c <= 4 && ack_at == 0; c++) begin
        tick();
        if (hs_ack) begin
          ack_at = c;
          hs_req = 1'b0;
        end
      end
      check("release_ack_at", ack_at, 2);
    end
    ps_req = 1'b0; hs_req = 1'b0;
    tick();
    tick();

    // Reset during a sequencer issue
    ps_req = 1'b1; ps_cmd = 14'h0777; ps_dt = 16'hA5A5;
    tick();
    ps_req = 1'b0;
    #1 check("rps_en_before", dg_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rps_en", dg_en, 0);
    check("rps_cmd", dg_cmd, 0);
    check("rps_bc", bc_dt, 0);
    #3 rst_n = 1'b1;
    tick();

    // Reset during a host read
    hs_req = 1'b1; hs_wr = 1'b0; hs_add = 5'b00111; dg_bc_dt = 16'hCAFE;
    tick();
    #1 check("rhr_rd_add_before", dg_rd_add, 7);
    #1 rst_n = 1'b0;
    hs_req = 1'b0;
    #1;
    check("rhr_rd_add", dg_rd_add, 0);
    check("rhr_rdt", hs_rdt, 0);
    check("rhr_ack", hs_ack, 0);
    tick();
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (hs_ack) ack_cnt++;
    end
    check("rhr_no_ack", ack_cnt, 0);
    check("rhr_rdt_after", hs_rdt, 0);
    dg_bc_dt = 16'h0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
